// File: rtl/tribus_oe_sequencer.sv
// rtl/tribus_oe_sequencer.sv - round-robin output-enable sequencer for bufif0 drivers on a shared tristate net
module tribus_oe_sequencer #(
    parameter int N_DRV    = 4,
    parameter int TURN     = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_DRV-1:0]         req,
    input  logic [N_DRV-1:0]         done,
    output logic [N_DRV-1:0]         oe_n,
    output logic [$clog2(N_DRV)-1:0] grant_id,
    output logic                     bus_busy,
    output logic                     timeout
);

    localparam int IW = $clog2(N_DRV);
    localparam logic [N_DRV-1:0] ONE_HOT0 = N_DRV'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] winner;
    logic [7:0]    hold_cnt;
    logic [3:0]    turn_cnt;
    logic          rel_done;
    logic          rel_drop;
    logic          rel_max;

    // Round-robin pick: scan from the farthest candidate back to last+1 so the nearest set bit wins
    always_comb begin
        winner = '0;
        for (int i = N_DRV; i >= 1; i--) begin
            if (req[IW'((int'(last) + i) % N_DRV)]) begin
                winner = IW'((int'(last) + i) % N_DRV);
            end
        end
    end

    assign rel_done = done[grant_id];
    assign rel_drop = ~req[grant_id];
    assign rel_max  = (hold_cnt == 8'(MAX_HOLD));

    // Grant/hold/turnaround sequencing; reset floats the net immediately without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            oe_n     <= '1;
            grant_id <= '0;
            bus_busy <= 1'b0;
            timeout  <= 1'b0;
            last     <= IW'(N_DRV - 1);
            hold_cnt <= 8'd0;
            turn_cnt <= 4'd0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state    <= S_DRIVE;
                        oe_n     <= ~(ONE_HOT0 << winner);
                        bus_busy <= 1'b1;
                        grant_id <= winner;
                        last     <= winner;
                        hold_cnt <= 8'd1;
                    end
                end
                S_DRIVE: begin
                    if (rel_done || rel_drop || rel_max) begin
                        oe_n     <= '1;
                        bus_busy <= 1'b0;
                        hold_cnt <= 8'd0;
                        // A forced release is only reported when nothing else would have ended the grant
                        timeout  <= rel_max && !rel_done && !rel_drop;
                        if (TURN == 0) begin
                            state <= S_IDLE;
                        end else begin
                            state    <= S_TURN;
                            turn_cnt <= 4'(TURN);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                S_TURN: begin
                    if (turn_cnt <= 4'd1) begin
                        turn_cnt <= 4'd0;
                        state    <= S_IDLE;
                    end else begin
                        turn_cnt <= turn_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    oe_n  <= '1;
                end
            endcase
        end
    end

endmodule
